// File: rtl/vga_timing_detector.sv
// VGA timing detector: measures horizontal/vertical porch, sync and display lengths.
// Optional macro VGA_DET_STABILITY_CHECK_EN: lock only on two identical consecutive frames.
package vga_pkg;
  localparam int unsigned VGA_MAX_H_WIDTH = 12;
  localparam int unsigned VGA_MAX_V_WIDTH = 11;

  typedef struct packed {
    logic [VGA_MAX_H_WIDTH-1:0] hd;
    logic [VGA_MAX_H_WIDTH-1:0] hf;
    logic [VGA_MAX_H_WIDTH-1:0] hr;
    logic [VGA_MAX_H_WIDTH-1:0] hb;
    logic [VGA_MAX_V_WIDTH-1:0] vd;
    logic [VGA_MAX_V_WIDTH-1:0] vf;
    logic [VGA_MAX_V_WIDTH-1:0] vr;
    logic [VGA_MAX_V_WIDTH-1:0] vb;
  } vga_timing_t;
endpackage

module vga_timing_detector
  import vga_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic                       vga_hs_i,
  input  logic                       vga_vs_i,
  input  logic                       de_i,
  output logic [VGA_MAX_H_WIDTH-1:0] hd_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hf_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hr_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hb_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vd_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vf_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vr_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vb_o,
  output logic                       frame_valid_o,
  output logic                       locked_o,
  output logic                       err_o
);
  localparam int unsigned HW = VGA_MAX_H_WIDTH;
  localparam int unsigned VW = VGA_MAX_V_WIDTH;

  typedef enum logic [2:0] {H_IDLE, H_DISPLAY, H_FRONT, H_SYNC, H_BACK} h_state_t;
  typedef enum logic [2:0] {V_IDLE, V_BACK, V_DISPLAY, V_FRONT, V_SYNC} v_state_t;

  // Synchronizer chain {hs, vs, de} plus one stage of history for edge detection
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] last_q;
  logic       hs_s, vs_s, de_s;
  logic       hs_fall, hs_rise, vs_fall, vs_rise, de_fall, de_rise;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      last_q <= '0;
    end else begin
      sync_q[0] <= {vga_hs_i, vga_vs_i, de_i};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign {hs_s, vs_s, de_s} = sync_q[SYNC_STAGES-1];
  assign hs_fall = ~hs_s & last_q[2];
  assign hs_rise = hs_s & ~last_q[2];
  assign vs_fall = ~vs_s & last_q[1];
  assign vs_rise = vs_s & ~last_q[1];
  assign de_fall = ~de_s & last_q[0];
  assign de_rise = de_s & ~last_q[0];

  h_state_t    h_state_q, h_state_d;
  v_state_t    v_state_q, v_state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  vga_timing_t cap_q, cap_d, pub_q, pub_d;
  logic h_line_disp_q, h_line_disp_d, h_valid_q, h_valid_d, v_full_q, v_full_d;
  logic line_de_q, line_de_d, vs_rise_pend_q, vs_rise_pend_d, vs_fall_pend_q, vs_fall_pend_d;
  logic frame_valid_d, locked_d, err_c, publish_c, line_de_c, rise_pend_c, fall_pend_c;
`ifdef VGA_DET_STABILITY_CHECK_EN
  vga_timing_t prev_q, prev_d;
  logic        prev_valid_q, prev_valid_d;
`endif

  assign line_de_c   = line_de_q | de_s;
  assign rise_pend_c = vs_rise_pend_q | vs_rise;
  assign fall_pend_c = vs_fall_pend_q | vs_fall;

  // Next-state: horizontal FSM, vertical FSM, publication and error handling
  always_comb begin
    h_state_d      = h_state_q;
    v_state_d      = v_state_q;
    h_cnt_d        = (h_state_q == H_IDLE) ? '0 : h_cnt_q + HW'(1);
    v_cnt_d        = v_cnt_q;
    cap_d          = cap_q;
    pub_d          = pub_q;
    h_line_disp_d  = h_line_disp_q;
    h_valid_d      = h_valid_q;
    v_full_d       = v_full_q;
    line_de_d      = line_de_c;
    vs_rise_pend_d = rise_pend_c;
    vs_fall_pend_d = fall_pend_c;
    frame_valid_d  = 1'b0;
    locked_d       = locked_o;
    err_c          = 1'b0;
    publish_c      = 1'b0;
`ifdef VGA_DET_STABILITY_CHECK_EN
    prev_d         = prev_q;
    prev_valid_d   = prev_valid_q;
`endif

    case (h_state_q)
      H_IDLE:    if (de_rise) h_state_d = H_DISPLAY;
      H_DISPLAY: begin
        if (hs_fall) err_c = 1'b1;
        else if (de_fall) begin
          h_state_d     = H_FRONT;
          cap_d.hd      = h_cnt_q;
          h_line_disp_d = 1'b1;
        end
      end
      H_FRONT: begin
        if (de_rise) err_c = 1'b1;
        else if (hs_fall) begin
          h_state_d = H_SYNC;
          cap_d.hf  = h_cnt_q;
        end
      end
      H_SYNC: begin
        if (de_rise) err_c = 1'b1;
        else if (hs_rise) begin
          h_state_d = H_BACK;
          if (h_line_disp_q) cap_d.hr = h_cnt_q;
        end
      end
      H_BACK: begin
        // de rise wins; a coincident hs fall then lands in display and is an error
        if (de_rise) begin
          h_state_d = H_DISPLAY;
          if (h_line_disp_q) begin
            cap_d.hb  = h_cnt_q;
            h_valid_d = 1'b1;
          end
          if (hs_fall) err_c = 1'b1;
        end else if (hs_fall) begin
          h_state_d     = H_SYNC;
          h_line_disp_d = 1'b0;
        end
      end
      default: h_state_d = H_IDLE;
    endcase
    if (h_state_d != h_state_q) h_cnt_d = HW'(1);
    if (h_cnt_q == '1) err_c = 1'b1;

    if (hs_fall) begin
      line_de_d      = 1'b0;
      vs_rise_pend_d = 1'b0;
      vs_fall_pend_d = 1'b0;
      if (v_state_q != V_IDLE) v_cnt_d = v_cnt_q + VW'(1);
      case (v_state_q)
        // Only leave idle on a blank line, so a reset-induced vs edge mid-display is ignored
        V_IDLE: if (rise_pend_c && !line_de_c) v_state_d = V_BACK;
        V_BACK: if (line_de_c) begin
          v_state_d = V_DISPLAY;
          cap_d.vb  = v_cnt_q;
          publish_c = v_full_q & h_valid_q;
        end
        V_DISPLAY: if (!line_de_c) begin
          v_state_d = V_FRONT;
          cap_d.vd  = v_cnt_q;
        end
        V_FRONT: if (fall_pend_c) begin
          v_state_d = V_SYNC;
          cap_d.vf  = v_cnt_q;
        end
        V_SYNC: if (rise_pend_c) begin
          v_state_d = V_BACK;
          cap_d.vr  = v_cnt_q;
          v_full_d  = 1'b1;
        end
        default: v_state_d = V_IDLE;
      endcase
      if (v_state_d != v_state_q) v_cnt_d = VW'(1);
    end
    if (v_cnt_q == '1) err_c = 1'b1;
    if (vs_fall && (v_state_q == V_DISPLAY || v_state_q == V_BACK)) err_c = 1'b1;

    if (publish_c && !err_c) begin
      pub_d         = cap_d;
      frame_valid_d = 1'b1;
`ifdef VGA_DET_STABILITY_CHECK_EN
      locked_d      = prev_valid_q && (cap_d == prev_q);
      prev_d        = cap_d;
      prev_valid_d  = 1'b1;
`else
      locked_d      = 1'b1;
`endif
    end

    if (err_c) begin
      h_state_d      = H_IDLE;
      v_state_d      = V_IDLE;
      h_cnt_d        = '0;
      v_cnt_d        = '0;
      h_line_disp_d  = 1'b0;
      h_valid_d      = 1'b0;
      v_full_d       = 1'b0;
      line_de_d      = 1'b0;
      vs_rise_pend_d = 1'b0;
      vs_fall_pend_d = 1'b0;
      locked_d       = 1'b0;
`ifdef VGA_DET_STABILITY_CHECK_EN
      prev_valid_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      h_state_q      <= H_IDLE;
      v_state_q      <= V_IDLE;
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      cap_q          <= '0;
      pub_q          <= '0;
      h_line_disp_q  <= 1'b0;
      h_valid_q      <= 1'b0;
      v_full_q       <= 1'b0;
      line_de_q      <= 1'b0;
      vs_rise_pend_q <= 1'b0;
      vs_fall_pend_q <= 1'b0;
      frame_valid_o  <= 1'b0;
      locked_o       <= 1'b0;
      err_o          <= 1'b0;
`ifdef VGA_DET_STABILITY_CHECK_EN
      prev_q         <= '0;
      prev_valid_q   <= 1'b0;
`endif
    end else begin
      h_state_q      <= h_state_d;
      v_state_q      <= v_state_d;
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      cap_q          <= cap_d;
      pub_q          <= pub_d;
      h_line_disp_q  <= h_line_disp_d;
      h_valid_q      <= h_valid_d;
      v_full_q       <= v_full_d;
      line_de_q      <= line_de_d;
      vs_rise_pend_q <= vs_rise_pend_d;
      vs_fall_pend_q <= vs_fall_pend_d;
      frame_valid_o  <= frame_valid_d;
      locked_o       <= locked_d;
      err_o          <= err_c;
`ifdef VGA_DET_STABILITY_CHECK_EN
      prev_q         <= prev_d;
      prev_valid_q   <= prev_valid_d;
`endif
    end
  end

  assign hd_o = pub_q.hd;
  assign hf_o = pub_q.hf;
  assign hr_o = pub_q.hr;
  assign hb_o = pub_q.hb;
  assign vd_o = pub_q.vd;
  assign vf_o = pub_q.vf;
  assign vr_o = pub_q.vr;
  assign vb_o = pub_q.vb;

endmodule
